// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles framed serial bits into WIDTH-bit
// words and presents them through a one-entry valid/ready holding register.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bitIn,
  input  logic             bitValid,
  input  logic             frameStart,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  input  logic             dataReady,
  output logic             overrun,
  input  logic             clrOverrun,
  output logic             syncErr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [WIDTH-1:0] shifted_s, fresh_s, word_s;
  logic             word_done_s, sync_err_s, load_s;

  // Next-state logic for framing and bit assembly
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    word_s      = {WIDTH{1'b0}};
    word_done_s = 1'b0;
    sync_err_s  = 1'b0;

    // fresh_s seeds a new word so the first bit lands in its final position after WIDTH-1 shifts
    if (MSB_FIRST) begin
      shifted_s = {shift_r[WIDTH-2:0], bitIn};
      fresh_s   = {{(WIDTH-1){1'b0}}, bitIn};
    end else begin
      shifted_s = {bitIn, shift_r[WIDTH-1:1]};
      fresh_s   = {bitIn, {(WIDTH-1){1'b0}}};
    end

    case (state_r)
      HUNT: begin
        if (bitValid && frameStart) begin
          shift_s   = fresh_s;
          bit_cnt_s = CW'(1);
          state_s   = SHIFT;
        end else begin
          state_s = HUNT;
        end
      end
      SHIFT: begin
        if (bitValid && frameStart) begin
          shift_s    = fresh_s;
          bit_cnt_s  = CW'(1);
          sync_err_s = (bit_cnt_r != {CW{1'b0}});
        end else if (bitValid && (bit_cnt_r == LAST_CNT)) begin
          shift_s     = shifted_s;
          word_s      = shifted_s;
          word_done_s = 1'b1;
          bit_cnt_s   = {CW{1'b0}};
        end else if (bitValid) begin
          shift_s   = shifted_s;
          bit_cnt_s = bit_cnt_r + CW'(1);
        end else begin
          shift_s = shift_r;
        end
      end
      default: begin
        state_s   = HUNT;
        bit_cnt_s = {CW{1'b0}};
        shift_s   = {WIDTH{1'b0}};
      end
    endcase

    load_s = word_done_s && (!dataValid || dataReady);
  end

  // Framing state, counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= HUNT;
      bit_cnt_r <= {CW{1'b0}};
      shift_r   <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
    end
  end

  // Holding register, handshake and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut   <= {WIDTH{1'b0}};
      dataValid <= 1'b0;
      overrun   <= 1'b0;
      syncErr   <= 1'b0;
    end else begin
      syncErr <= sync_err_s;
      if (load_s) begin
        dataOut   <= word_s;
        dataValid <= 1'b1;
      end else if (dataValid && dataReady) begin
        dataValid <= 1'b0;
      end
      // a dropped word sets overrun even when a clear is requested
      if (word_done_s && !load_s) begin
        overrun <= 1'b1;
      end else if (clrOverrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (MSB-first main instance,
// LSB-first second instance sharing the same stimulus).
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset, bitIn, bitValid, frameStart, dataReady, clrOverrun;
  logic [7:0] dataOut, dataOut_lsb;
  logic       dataValid, overrun, syncErr;
  logic       dataValid_lsb, overrun_lsb, syncErr_lsb;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         sync_pulses = 0;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .bitIn(bitIn), .bitValid(bitValid),
    .frameStart(frameStart), .dataOut(dataOut), .dataValid(dataValid),
    .dataReady(dataReady), .overrun(overrun), .clrOverrun(clrOverrun),
    .syncErr(syncErr)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .bitIn(bitIn), .bitValid(bitValid),
    .frameStart(frameStart), .dataOut(dataOut_lsb), .dataValid(dataValid_lsb),
    .dataReady(dataReady), .overrun(overrun_lsb), .clrOverrun(clrOverrun),
    .syncErr(syncErr_lsb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (syncErr) sync_pulses++;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bitIn = b; bitValid = 1'b1; frameStart = fs;
    @(posedge clk); #1;
    bitValid = 1'b0; frameStart = 1'b0; bitIn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [7:0] w, input logic fs);
    for (int i = 7; i >= 0; i--) send_bit(w[i], fs && (i == 7));
  endtask

  task automatic test_reset;
    reset = 1'b1; bitIn = 1'b0; bitValid = 1'b0; frameStart = 1'b0;
    dataReady = 1'b0; clrOverrun = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("reset_dataOut", dataOut, 8'h00);
    chk("reset_dataValid", {7'd0, dataValid}, 8'h00);
    chk("reset_overrun", {7'd0, overrun}, 8'h00);
    chk("reset_syncErr", {7'd0, syncErr}, 8'h00);
  endtask

  task automatic test_basic;
    logic [7:0] w;
    w = 8'hA5;
    dataReady = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
    chk("basic_no_early_valid", {7'd0, dataValid}, 8'h00);
    send_bit(w[0], 1'b0);
    chk("basic_valid", {7'd0, dataValid}, 8'h01);
    chk("basic_data", dataOut, 8'hA5);
    idle(1);
    chk("basic_valid_drop", {7'd0, dataValid}, 8'h00);
    chk("basic_data_hold", dataOut, 8'hA5);
  endtask

  task automatic test_gaps;
    logic [7:0] w;
    int         s0;
    w = 8'h3C;
    s0 = sync_pulses;
    for (int i = 7; i >= 1; i--) begin
      send_bit(w[i], i == 7);
      idle(2);
    end
    send_bit(w[0], 1'b0);
    chk("gaps_valid", {7'd0, dataValid}, 8'h01);
    chk("gaps_data", dataOut, 8'h3C);
    chk("gaps_overrun", {7'd0, overrun}, 8'h00);
    chk("gaps_syncerr", 8'(sync_pulses - s0), 8'h00);
    idle(1);
    chk("gaps_valid_drop", {7'd0, dataValid}, 8'h00);
  endtask

  task automatic test_back_to_back_overrun;
    dataReady = 1'b0;
    send_word(8'h12, 1'b1);
    chk("ovr_first_valid", {7'd0, dataValid}, 8'h01);
    chk("ovr_first_no_overrun", {7'd0, overrun}, 8'h00);
    send_word(8'h34, 1'b0);
    chk("ovr_data_held", dataOut, 8'h12);
    chk("ovr_set", {7'd0, overrun}, 8'h01);
    idle(2);
    chk("ovr_sticky", {7'd0, overrun}, 8'h01);
    clrOverrun = 1'b1;
    idle(1);
    clrOverrun = 1'b0;
    chk("ovr_cleared", {7'd0, overrun}, 8'h00);
    chk("ovr_still_valid", {7'd0, dataValid}, 8'h01);
    dataReady = 1'b1;
    idle(1);
    chk("ovr_drain_valid", {7'd0, dataValid}, 8'h00);
    chk("ovr_drain_data", dataOut, 8'h12);
  endtask

  task automatic test_sync_err;
    logic [7:0] w;
    int         s0;
    w = 8'hC3;
    dataReady = 1'b1;
    s0 = sync_pulses;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("sync_quiet_before", {7'd0, syncErr}, 8'h00);
    send_bit(w[7], 1'b1);
    chk("sync_pulse", {7'd0, syncErr}, 8'h01);
    send_bit(w[6], 1'b0);
    chk("sync_pulse_end", {7'd0, syncErr}, 8'h00);
    for (int i = 5; i >= 0; i--) send_bit(w[i], 1'b0);
    chk("sync_valid", {7'd0, dataValid}, 8'h01);
    chk("sync_data", dataOut, 8'hC3);
    chk("sync_pulse_count", 8'(sync_pulses - s0), 8'h01);
    idle(1);
  endtask

  task automatic test_simultaneous;
    logic [7:0] w;
    w = 8'hAA;
    dataReady = 1'b0;
    send_word(8'h55, 1'b1);
    chk("simul_first", dataOut, 8'h55);
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    dataReady = 1'b1;
    send_bit(w[0], 1'b0);
    chk("simul_valid_stays", {7'd0, dataValid}, 8'h01);
    chk("simul_data", dataOut, 8'hAA);
    chk("simul_no_overrun", {7'd0, overrun}, 8'h00);
    idle(1);
    chk("simul_drain", {7'd0, dataValid}, 8'h00);
  endtask

  task automatic test_reset_mid;
    logic       rose;
    logic [7:0] w;
    w = 8'hA5;
    dataReady = 1'b0;
    send_word(8'hF0, 1'b1);
    chk("rst_pre_valid", {7'd0, dataValid}, 8'h01);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    #2;
    chk("rst_async_valid", {7'd0, dataValid}, 8'h00);
    chk("rst_async_data", dataOut, 8'h00);
    idle(1);
    reset = 1'b0;
    dataReady = 1'b1;
    rose = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], 1'b0);
      if (dataValid) rose = 1'b1;
    end
    idle(2);
    chk("rst_never_valid", {7'd0, rose}, 8'h00);
    chk("rst_data", dataOut, 8'h00);
    chk("rst_overrun", {7'd0, overrun}, 8'h00);
    chk("rst_syncErr", {7'd0, syncErr}, 8'h00);
    chk("rst_lsb_valid", {7'd0, dataValid_lsb}, 8'h00);
  endtask

  task automatic test_lsb_first;
    logic [7:0] seq;
    seq = 8'b1010_0000;
    for (int i = 7; i >= 0; i--) send_bit(seq[i], i == 7);
    chk("lsb_valid", {7'd0, dataValid_lsb}, 8'h01);
    chk("lsb_data", dataOut_lsb, 8'h05);
    chk("lsb_msb_ref_data", dataOut, 8'hA0);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back_overrun();
    test_sync_err();
    test_simultaneous();
    test_reset_mid();
    test_lsb_first();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
